// File: rtl/multdiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Op codes follow the op port; FSM states are IDLE, RUN, DONE.
package multdiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/multdiv_addsub.sv
// N-bit adder/subtractor with carry-out.
// Shared by Booth steps, restoring steps and sign negations.
module multdiv_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] full;

  assign full = {1'b0, a}
              + {1'b0, b ^ {N{sub}}}
              + {{N{1'b0}}, sub};

  assign co  = full[N];
  assign sum = full[N-1:0];

endmodule

// File: rtl/multdiv_seq.sv
// Sequential radix-2 Booth multiplier / restoring divider.
// WIDTH iterations per op, one DONE cycle with a result pulse.
module multdiv_seq #(
  parameter int WIDTH          = 32,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception
);

  import multdiv_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ZERO = '0;
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  op_e              op_r;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic             dz;
  logic             ovf;
  logic             q1;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mq;

  logic             is_div;
  logic [1:0]       booth;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   mul_acc;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] mq_n;
  logic             q1_n;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] res_n;
  logic             exc_n;

  logic [WIDTH:0]   nega_sum;
  logic [WIDTH:0]   negb_sum;
  logic             nega_co;
  logic             negb_co;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH:0]   step_a;
  logic [WIDTH:0]   step_sum;
  logic             step_sub;
  logic             step_co;

  logic [WIDTH:0]   post_a;
  logic [WIDTH:0]   post_b;
  logic [WIDTH:0]   post_sum;
  logic             post_co;

  logic             unused_ok;

  // Operand magnitudes for the divider, formed at start time
  multdiv_addsub #(.N(WIDTH + 1)) u_nega (
    .a   (ZERO),
    .b   ({data_operandA[WIDTH-1], data_operandA}),
    .sub (1'b1),
    .sum (nega_sum),
    .co  (nega_co)
  );

  multdiv_addsub #(.N(WIDTH + 1)) u_negb (
    .a   (ZERO),
    .b   ({data_operandB[WIDTH-1], data_operandB}),
    .sub (1'b1),
    .sum (negb_sum),
    .co  (negb_co)
  );

  assign mag_a = (is_signed && data_operandA[WIDTH-1])
               ? nega_sum[WIDTH-1:0] : data_operandA;
  assign mag_b = (is_signed && data_operandB[WIDTH-1])
               ? negb_sum[WIDTH-1:0] : data_operandB;

  assign is_div   = (op_r == OP_DIV) || (op_r == OP_REM);
  assign booth    = {mq[0], q1};
  assign shifted  = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign step_a   = is_div ? shifted : acc;
  assign step_sub = is_div || (booth == 2'b10);

  multdiv_addsub #(.N(WIDTH + 1)) u_step (
    .a   (step_a),
    .b   (mcand),
    .sub (step_sub),
    .sum (step_sum),
    .co  (step_co)
  );

  always_comb begin
    acc_n   = acc;
    mq_n    = mq;
    q1_n    = q1;
    mul_acc = acc;
    if (is_div) begin
      acc_n = step_co ? step_sum : shifted;
      mq_n  = {mq[WIDTH-2:0], step_co};
    end else begin
      mul_acc = (booth[1] ^ booth[0]) ? step_sum : acc;
      acc_n   = {mul_acc[WIDTH], mul_acc[WIDTH:1]};
      mq_n    = {mul_acc[0], mq[WIDTH-1:1]};
      q1_n    = mq[0];
    end
  end

  // Unsigned multiplier with MSB set: Booth saw B-2^W, add A<<W back
  assign post_a = is_div ? ZERO : acc_n;
  assign post_b = !is_div ? mcand
                : (op_r == OP_REM) ? {1'b0, acc_n[WIDTH-1:0]}
                : {1'b0, mq_n};

  multdiv_addsub #(.N(WIDTH + 1)) u_post (
    .a   (post_a),
    .b   (post_b),
    .sub (is_div),
    .sum (post_sum),
    .co  (post_co)
  );

  assign hi = (!sgn && sb) ? post_sum[WIDTH-1:0]
                           : acc_n[WIDTH-1:0];

  always_comb begin
    res_n = '0;
    exc_n = 1'b0;
    unique case (1'b1)
      op_r == OP_MUL: begin
        res_n = mq_n;
        exc_n = sgn ? (hi != {WIDTH{mq_n[WIDTH-1]}})
                    : (hi != '0);
      end
      op_r == OP_MULH: begin
        res_n = hi;
      end
      op_r == OP_DIV: begin
        res_n = dz ? '0
              : (sgn && (sa ^ sb)) ? post_sum[WIDTH-1:0]
              : mq_n;
        exc_n = dz || ovf;
      end
      op_r == OP_REM: begin
        res_n = (sgn && sa) ? post_sum[WIDTH-1:0]
                            : acc_n[WIDTH-1:0];
        exc_n = dz || ovf;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      cnt            <= '0;
      sgn            <= SIGNED_DEFAULT;
      op_r           <= OP_MUL;
      acc            <= '0;
      mcand          <= '0;
      mq             <= '0;
      q1             <= 1'b0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      dz             <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          data_resultRDY <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            op_r  <= op_e'(op);
            sgn   <= is_signed;
            sa    <= data_operandA[WIDTH-1];
            sb    <= data_operandB[WIDTH-1];
            dz    <= (data_operandB == '0);
            ovf   <= is_signed
                  && (data_operandA == MIN)
                  && (data_operandB == '1);
            acc   <= '0;
            q1    <= 1'b0;
            if (op[1]) begin
              mq    <= mag_a;
              mcand <= {1'b0, mag_b};
            end else begin
              mq    <= data_operandB;
              mcand <= {is_signed & data_operandA[WIDTH-1],
                        data_operandA};
            end
          end
        end
        RUN: begin
          acc <= acc_n;
          mq  <= mq_n;
          q1  <= q1_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state          <= DONE;
            data_resultRDY <= 1'b1;
            data_result    <= res_n;
            data_exception <= exc_n;
          end
        end
        DONE: begin
          state          <= IDLE;
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign unused_ok = ^{nega_sum[WIDTH], negb_sum[WIDTH],
                       nega_co, negb_co, post_co,
                       post_sum[WIDTH]};

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq at WIDTH=32: directed corner cases,
// randomized ops against an arithmetic model, restart and abort.
module tb_multdiv_seq;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         is_signed = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         busy;
  logic         data_resultRDY;
  logic [W-1:0] data_result;
  logic         data_exception;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  o;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  multdiv_seq #(.WIDTH(W), .SIGNED_DEFAULT(1'b1)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .op             (op),
    .is_signed      (is_signed),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_result    (data_result),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  function automatic void model(
    input  logic [1:0]  o,
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        e
  );
    logic [63:0] ea, eb, p;
    longint sa_, sb_;
    r = '0;
    e = 1'b0;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    p = ea * eb;
    if (o == 2'b00) begin
      r = p[31:0];
      e = s ? (p[63:32] != {32{p[31]}})
            : (p[63:32] != 32'd0);
    end else if (o == 2'b01) begin
      r = p[63:32];
    end else if (b == 32'd0) begin
      e = 1'b1;
      r = (o == 2'b10) ? 32'd0 : a;
    end else if (s && a == 32'h80000000
                 && b == 32'hFFFFFFFF) begin
      e = 1'b1;
      r = (o == 2'b10) ? 32'h80000000 : 32'd0;
    end else if (s) begin
      sa_ = longint'($signed(a));
      sb_ = longint'($signed(b));
      r = (o == 2'b10) ? 32'(sa_ / sb_)
                       : 32'(sa_ % sb_);
    end else begin
      r = (o == 2'b10) ? a / b : a % b;
    end
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(posedge clock);
      #1;
      guard++;
    end
  endtask

  // Latency counts clock edges from the start-sampling edge (1)
  // through the edge that raises data_resultRDY.
  task automatic do_op(
    input  logic [1:0]  o,
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic        e,
    output int          lat
  );
    wait_idle();
    @(negedge clock);
    op = o;
    is_signed = s;
    data_operandA = a;
    data_operandB = b;
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      start = 1'b0;
      lat++;
    end while (!data_resultRDY && lat < 100);
    r = data_result;
    e = data_exception;
  endtask

  function automatic logic [31:0] pick();
    int k;
    k = int'($urandom_range(0, 9));
    case (k)
      0: pick = 32'd0;
      1: pick = 32'd1;
      2: pick = 32'hFFFFFFFF;
      3: pick = 32'h80000000;
      4: pick = 32'h7FFFFFFF;
      5: pick = $urandom_range(0, 255);
      6: pick = -$urandom_range(1, 255);
      default: pick = $urandom;
    endcase
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    tests++;
    if (data_resultRDY !== 1'b0) begin
      fails++;
      $display("FAIL reset_rdy got %b want 0",
               data_resultRDY);
    end
    tests++;
    if (data_result !== 32'd0) begin
      fails++;
      $display("FAIL reset_result got %h want 0",
               data_result);
    end
    tests++;
    if (data_exception !== 1'b0) begin
      fails++;
      $display("FAIL reset_exc got %b want 0",
               data_exception);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    logic [31:0] r;
    logic e;
    int lat;
    v.push_back('{2'b00, 1'b1, 32'hFFFFFFF9, 32'd6,
                  32'hFFFFFFD6, 1'b0});
    v.push_back('{2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 1'b0});
    v.push_back('{2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h00000001, 1'b1});
    v.push_back('{2'b10, 1'b1, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFD, 1'b0});
    v.push_back('{2'b11, 1'b1, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFF, 1'b0});
    v.push_back('{2'b10, 1'b1, 32'd100, 32'd0,
                  32'd0, 1'b1});
    v.push_back('{2'b11, 1'b1, 32'd100, 32'd0,
                  32'd100, 1'b1});
    v.push_back('{2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF,
                  32'h80000000, 1'b1});
    v.push_back('{2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF,
                  32'd0, 1'b1});
    v.push_back('{2'b01, 1'b1, 32'h80000000, 32'h80000000,
                  32'h40000000, 1'b0});
    v.push_back('{2'b00, 1'b1, 32'h80000000, 32'h80000000,
                  32'h00000000, 1'b1});
    v.push_back('{2'b10, 1'b0, 32'hFFFFFFFF, 32'd16,
                  32'h0FFFFFFF, 1'b0});
    v.push_back('{2'b11, 1'b0, 32'hFFFFFFFF, 32'd0,
                  32'hFFFFFFFF, 1'b1});
    foreach (v[i]) begin
      do_op(v[i].o, v[i].s, v[i].a, v[i].b, r, e, lat);
      tests++;
      if (r !== v[i].r) begin
        fails++;
        $display("FAIL dir%0d_result got %h want %h",
                 i, r, v[i].r);
      end
      tests++;
      if (e !== v[i].e) begin
        fails++;
        $display("FAIL dir%0d_exc got %b want %b",
                 i, e, v[i].e);
      end
      tests++;
      if (lat != 33) begin
        fails++;
        $display("FAIL dir%0d_latency got %0d want 33",
                 i, lat);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] o;
    logic s;
    logic [31:0] a, b, r, xr;
    logic e, xe;
    int lat;
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      model(o, s, a, b, xr, xe);
      do_op(o, s, a, b, r, e, lat);
      tests++;
      if (r !== xr || e !== xe || lat != 33) begin
        fails++;
        $display({"FAIL rand%0d op=%0d s=%0d a=%h b=%h ",
                  "got %h/%b/%0d want %h/%b/33"},
                 n, o, s, a, b, r, e, lat, xr, xe);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] r;
    logic e;
    int lat;
    do_op(2'b10, 1'b0, 32'd1000, 32'd7, r, e, lat);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL done_busy got %b want 1", busy);
    end
    @(posedge clock);
    #1;
    tests++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL pulse_width rdy=%b busy=%b want 0/0",
               data_resultRDY, busy);
    end
    repeat (4) @(posedge clock);
    #1;
    tests++;
    if (data_result !== 32'd142 || data_exception !== 1'b0)
    begin
      fails++;
      $display("FAIL hold got %h/%b want 0000008e/0",
               data_result, data_exception);
    end
  endtask

  task automatic test_restart_ignored();
    int pulses;
    int first_lat;
    logic [31:0] first_r;
    pulses = 0;
    first_lat = 0;
    first_r = '0;
    wait_idle();
    @(negedge clock);
    op = 2'b00;
    is_signed = 1'b1;
    data_operandA = 32'hFFFFFFF9;
    data_operandB = 32'd6;
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        start = 1'b1;
        op = 2'b10;
        data_operandA = 32'd12345;
        data_operandB = 32'd7;
      end
      if (c == 6) start = 1'b0;
      if (data_resultRDY) begin
        pulses++;
        if (pulses == 1) begin
          first_lat = c;
          first_r = data_result;
        end
      end
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL restart_pulses got %0d want 1", pulses);
    end
    tests++;
    if (first_lat != 33) begin
      fails++;
      $display("FAIL restart_latency got %0d want 33",
               first_lat);
    end
    tests++;
    if (first_r !== 32'hFFFFFFD6) begin
      fails++;
      $display("FAIL restart_result got %h want ffffffd6",
               first_r);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] r;
    logic e;
    int lat;
    int pulses;
    do_op(2'b00, 1'b1, 32'hFFFFFFF9, 32'd6, r, e, lat);
    tests++;
    if (r !== 32'hFFFFFFD6) begin
      fails++;
      $display("FAIL pre_abort got %h want ffffffd6", r);
    end
    pulses = 0;
    wait_idle();
    @(negedge clock);
    op = 2'b10;
    is_signed = 1'b0;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    start = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) start = 1'b0;
      if (c == 10) begin
        reset = 1'b1;
        start = 1'b1;
      end
      if (c == 11) begin
        reset = 1'b0;
        start = 1'b0;
      end
      if (data_resultRDY) pulses++;
      if (c == 12) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL abort_start_ignored busy=%b want 0",
                   busy);
        end
      end
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL abort_pulses got %0d want 0", pulses);
    end
    tests++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0 ||
        data_result !== 32'd0 || data_exception !== 1'b0)
    begin
      fails++;
      $display("FAIL abort_outputs got %b/%b/%h/%b want 0",
               busy, data_resultRDY, data_result,
               data_exception);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_restart_ignored();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
